booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Iterative radix-2 Booth multiplier, parametrised in operand width, with a
//  signed/unsigned mode select. Retires one multiplier bit per clock.
//  Operands arrive on a ready/valid input handshake. The product leaves on a
//  valid/ready output handshake that holds under backpressure.
//  Serves arithmetic datapaths where area matters more than latency. Handles
//  the most-negative operand with no special-case correction.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operands x, y, is_signed are valid
//  in_ready   out  1          block can accept operands (high only in IDLE)
//  x          in   WIDTH      multiplier
//  y          in   WIDTH      multiplicand
//  is_signed  in   1          1: two's-complement operands; 0: unsigned
//  out_valid  out  1          product valid; held until accepted
//  out_ready  in   1          consumer accepts product
//  product    out  2*WIDTH    x*y, two's-complement if signed, else unsigned
//  busy       out  1          high in CALC or DONE
// BEHAVIOUR
//  - Reset values: in_ready=1, out_valid=0, busy=0, product=0, state=IDLE.
//    All internal registers clear to 0.
//  - Reset is synchronous: rst high at a clock edge overrides every other input.
//    A reset during CALC or DONE discards the operation; no out_valid follows.
//  - Operand extension to E=WIDTH+1 bits: sign-extend if is_signed, else
//    zero-extend. is_signed is sampled only at accept.
//  - Registers:
//    - A: E+1 bits, the accumulator with a guard bit.
//    - Q: E bits, the multiplier.
//    - q_1: 1 bit, the Booth history bit.
//    - M: E+1 bits, the sign-extended multiplicand.
//    - cnt: $clog2(E+1) bits.
//  - IDLE: in_ready=1. On in_valid & in_ready: A<=0, Q<=ext(x), q_1<=0,
//    M<=ext(y), cnt<=E; go to CALC.
//  - CALC: in_ready=0. Each cycle, select on {Q[0],q_1}:
//    - 10: A-M.
//    - 01: A+M.
//    - 00 or 11: A unchanged.
//    Then arithmetic-shift {A,Q,q_1} right by 1, preserving A's MSB.
//    cnt<=cnt-1. When cnt==1, take the last step, then go to DONE.
//  - DONE: out_valid=1. product={A,Q}[2*WIDTH-1:0], registered and stable
//    while out_valid & !out_ready.
//    - On out_ready: return to IDLE with out_valid=0 on the next cycle.
//  - Latency: the accept edge, then WIDTH+1 CALC cycles, then out_valid is
//    high in the following cycle. Throughput is one product per WIDTH+3
//    cycles when out_ready is held high.
//  - in_valid outside IDLE is ignored. Operands are not buffered, so the
//    producer must hold them until in_ready.
//  - Width rule: -2^(W-1) * -2^(W-1) = 2^(2W-2) fits in 2W bits as a signed
//    value. Unsigned (2^W-1)^2 < 2^(2W). No overflow is possible in either mode.
//  - x=0 or y=0 still runs the full iteration count; there is no early exit.
// STRUCTURE
//  - Shared include booth_pkg.vh holds the state encoding:
//    ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
//  - It also holds the helper function/localparam for cnt width,
//    $clog2(WIDTH+2).
//  - Sub-module booth_step: combinational, parametrised on E. Inputs A, Q,
//    q_1, M; outputs next A, Q, q_1 after one add/sub plus arithmetic shift.
//  - booth_mult_seq holds the FSM, counter, operand registers and output
//    register.
// TESTING
//  1. WIDTH=4, signed, x=-8 (4'h8), y=-8 -> product=8'h40 (+64) after 6 cycles.
//  2. WIDTH=8, signed, x=127, y=-128 -> product=16'hC080 (-16256).
//     x=-1, y=1 -> 16'hFFFF.
//  3. WIDTH=8, unsigned, x=255, y=255 -> product=16'hFE01.
//     The same bits with is_signed=1 -> 16'h0001.
//  4. Backpressure:
//     - Hold out_ready=0 for 5 cycles after out_valid; product and out_valid
//       must stay stable and in_ready must stay 0.
//     - in_valid pulses during CALC are ignored.
//  5. Assert rst 3 cycles into CALC.
//     - Next cycle: in_ready=1, out_valid=0.
//     - A new operation, 3*5, then yields 15.
//  6. Randomised sweep, WIDTH in {4,8,16}, both modes, out_ready random.
//     - Every product matches a reference multiply.
//     - Accept-to-out_valid latency is exactly WIDTH+2.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state encoding
// and the iteration-counter width helper.
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // The counter has to hold E = WIDTH+1, the number of Booth steps.
   function automatic int cnt_w(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int E = 9
) (
   input  logic [E:0]   a,
   input  logic [E-1:0] q,
   input  logic         q_1,
   input  logic [E:0]   m,
   output logic [E:0]   a_nxt,
   output logic [E-1:0] q_nxt,
   output logic         q_1_nxt
);

   logic [E:0] sum;

   always_comb begin
      sum = a;
      case ({q[0], q_1})
         2'b10:   sum = a - m;
         2'b01:   sum = a + m;
         default: sum = a;
      endcase
      a_nxt   = {sum[E], sum[E:1]};
      q_nxt   = {sum[0], q[E-1:1]};
      q_1_nxt = q[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one multiplier bit per clock, with
// ready/valid operand intake and a held valid/ready product output.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int E  = WIDTH + 1;
   localparam int CW = cnt_w(WIDTH);

   state_e               state_q, state_d;
   logic [E:0]           a_q, a_d;
   logic [E-1:0]         q_q, q_d;
   logic                 q1_q, q1_d;
   logic [E:0]           m_q, m_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [E:0]           a_nxt;
   logic [E-1:0]         q_nxt;
   logic                 q1_nxt;

   booth_step #(.E(E)) u_step (
      .a       (a_q),
      .q       (q_q),
      .q_1     (q1_q),
      .m       (m_q),
      .a_nxt   (a_nxt),
      .q_nxt   (q_nxt),
      .q_1_nxt (q1_nxt)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // One extra bit makes unsigned operands look non-negative to Booth.
               a_d     = '0;
               q_d     = {is_signed & x[WIDTH-1], x};
               q1_d    = 1'b0;
               m_d     = {{2{is_signed & y[WIDTH-1]}}, y};
               cnt_d   = CW'(E);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            a_d   = a_nxt;
            q_d   = q_nxt;
            q1_d  = q1_nxt;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               prod_d  = {a_nxt[WIDTH-2:0], q_nxt};
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
   assign product   = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench: three multiplier instances (WIDTH 4, 8, 16), each with its
// own driver, out_ready policy and monitor checking products and latency.
module tb_booth_mult_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit done_f [3];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;

      logic               rst, in_valid, in_ready, is_signed;
      logic               out_valid, out_ready, busy;
      logic [W-1:0]       x, y;
      logic [2*W-1:0]     product;
      logic [2*W-1:0]     exp_q [$];
      int                 acc_q [$];
      int                 or_mode = 0;
      int                 stall   = 0;

      booth_mult_seq #(.WIDTH(W)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .x         (x),
         .y         (y),
         .is_signed (is_signed),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .product   (product),
         .busy      (busy)
      );

      function automatic logic [2*W-1:0] ref_mul(input int xx, input int yy, input bit sg);
         longint mask, xv, yv, p;
         mask = (longint'(1) << W) - 1;
         xv   = longint'(xx) & mask;
         yv   = longint'(yy) & mask;
         if (sg && xv[W-1]) xv = xv - (longint'(1) << W);
         if (sg && yv[W-1]) yv = yv - (longint'(1) << W);
         p = xv * yv;
         return p[2*W-1:0];
      endfunction

      task automatic send(input int xx, input int yy, input bit sg,
                          input logic [63:0] ex, input bit keep);
         int k;
         k = 0;
         @(posedge clk); #1;
         while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
         end
         if (!in_ready) begin
            bound_fail($sformatf("w%0d_in_ready_wait", W));
            return;
         end
         x         = W'(xx);
         y         = W'(yy);
         is_signed = sg;
         in_valid  = 1'b1;
         if (keep) exp_q.push_back(ex[2*W-1:0]);
         @(posedge clk); #1;
         in_valid = 1'b0;
      endtask

      task automatic wait_idle();
         int k;
         k = 0;
         while (!(exp_q.size() == 0 && in_ready) && k < 500) begin
            @(posedge clk); #1;
            k++;
         end
         if (!(exp_q.size() == 0 && in_ready)) bound_fail($sformatf("w%0d_drain", W));
      endtask

      // out_ready policy: 0 always ready, 1 random, 2 stall 5 cycles per product
      initial begin
         out_ready = 1'b1;
         forever begin
            @(posedge clk); #1;
            case (or_mode)
               1: out_ready = 1'($urandom % 2);
               2: begin
                  if (out_valid && stall < 5) begin
                     out_ready = 1'b0;
                     stall++;
                  end else begin
                     out_ready = 1'b1;
                     if (!out_valid) stall = 0;
                  end
               end
               default: out_ready = 1'b1;
            endcase
         end
      end

      initial begin
         logic           hold;
         logic [2*W-1:0] held;
         logic [2*W-1:0] e;
         int             a;
         hold = 1'b0;
         held = '0;
         forever begin
            @(negedge clk);
            if (rst) begin
               hold = 1'b0;
            end else begin
               if (in_valid && in_ready) acc_q.push_back(cyc);
               if (hold) begin
                  check($sformatf("w%0d_hold_valid", W), 64'(out_valid), 64'(1));
                  check($sformatf("w%0d_hold_product", W), 64'(product), 64'(held));
                  check($sformatf("w%0d_hold_in_ready", W), 64'(in_ready), 64'(0));
               end else if (out_valid) begin
                  if (exp_q.size() == 0) begin
                     bound_fail($sformatf("w%0d_unexpected_output", W));
                  end else begin
                     e = exp_q.pop_front();
                     check($sformatf("w%0d_product", W), 64'(product), 64'(e));
                  end
                  if (acc_q.size() == 0) begin
                     bound_fail($sformatf("w%0d_no_accept_seen", W));
                  end else begin
                     a = acc_q.pop_front();
                     check($sformatf("w%0d_latency", W), 64'(cyc - a), 64'(W + 2));
                  end
               end
               hold = out_valid && !out_ready;
               held = product;
            end
         end
      end

      initial begin
         int xx, yy;
         bit sg;
         rst       = 1'b1;
         in_valid  = 1'b0;
         x         = '0;
         y         = '0;
         is_signed = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("w%0d_rst_in_ready", W), 64'(in_ready), 64'(1));
         check($sformatf("w%0d_rst_out_valid", W), 64'(out_valid), 64'(0));
         check($sformatf("w%0d_rst_busy", W), 64'(busy), 64'(0));
         check($sformatf("w%0d_rst_product", W), 64'(product), 64'(0));
         @(posedge clk); #1;
         rst = 1'b0;

         if (W == 4) begin
            send(8, 8, 1, 64'h40, 1);
            send(15, 15, 0, 64'hE1, 1);
            send(15, 15, 1, 64'h01, 1);
         end else if (W == 8) begin
            send(127, -128, 1, 64'hC080, 1);
            send(-1, 1, 1, 64'hFFFF, 1);
            send(255, 255, 0, 64'hFE01, 1);
            send(255, 255, 1, 64'h0001, 1);
            send(0, 'h55, 0, 64'h0, 1);
            send(-128, -128, 1, 64'h4000, 1);
            wait_idle();
            // Backpressure plus stray in_valid pulses while computing.
            or_mode = 2;
            send(12, 10, 0, 64'h78, 1);
            repeat (3) begin
               x = W'(200);
               y = W'(200);
               in_valid = 1'b1;
               @(posedge clk); #1;
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
            wait_idle();
            or_mode = 0;
            // Abort an operation mid-CALC.
            send(100, 100, 0, 64'h0, 0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("w8_abort_in_ready", 64'(in_ready), 64'(1));
            check("w8_abort_out_valid", 64'(out_valid), 64'(0));
            check("w8_abort_busy", 64'(busy), 64'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            acc_q.delete();
            send(3, 5, 0, 64'hF, 1);
         end else begin
            send('h8000, 'h8000, 1, 64'h4000_0000, 1);
            send('hFFFF, 'hFFFF, 0, 64'hFFFE_0001, 1);
            send('h7FFF, 'h8000, 1, 64'hC000_8000, 1);
         end
         wait_idle();

         or_mode = 1;
         repeat (24) begin
            xx = int'($urandom);
            yy = int'($urandom);
            sg = 1'($urandom % 2);
            send(xx, yy, sg, 64'(ref_mul(xx, yy, sg)), 1);
         end
         wait_idle();
         done_f[gi] = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(done_f[0] && done_f[1] && done_f[2]) && t < 40000) begin
         @(posedge clk);
         t++;
      end
      if (!(done_f[0] && done_f[1] && done_f[2])) bound_fail("global_timeout");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
